// File: rtl/l1_instr_fetch_ctrl.sv
// l1_instr_fetch_ctrl: fetch controller in front of the L1 instruction cache set.
// Looks up the addressed line (and the following line for a straddling fetch),
// refills missing lines from L2 one at a time, then re-looks-up and returns a
// 32-bit little-endian instruction.
// Optional feature macro: L1I_PERF_CNT_EN adds saturating hit/miss counters.
module l1_instr_fetch_ctrl #(
    parameter int unsigned block_size = 128,
    parameter int unsigned tag_size   = 9,
    parameter int unsigned idx_size   = 6
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               fetch_req_i,
    input  logic [tag_size+idx_size+3:0]       fetch_addr_i,
    output logic                               fetch_ready_o,
    output logic                               instr_valid_o,
    output logic [31:0]                        instr_o,
    output logic [tag_size+idx_size-1:0]       set_tag_and_idx_o,
    output logic [block_size-1:0]              set_block_o,
    output logic                               set_we_o,
    output logic                               set_we_next_o,
    input  logic [block_size-1:0]              set_block_i,
    input  logic                               set_valid_i,
    input  logic [tag_size-1:0]                set_tag_i,
    input  logic [15:0]                        set_block_next_i,
    input  logic                               set_valid_next_i,
    input  logic [tag_size-1:0]                set_tag_next_i,
    output logic                               l2_req_o,
    output logic [tag_size+idx_size-1:0]       l2_addr_o,
    input  logic                               l2_ack_i,
`ifdef L1I_PERF_CNT_EN
    output logic [31:0]                        hit_cnt_o,
    output logic [31:0]                        miss_cnt_o,
`endif
    input  logic [block_size-1:0]              l2_block_i
);

    localparam int unsigned LINE_W = tag_size + idx_size;
    localparam int unsigned ADDR_W = LINE_W + 4;
    localparam int unsigned SEL_W  = $clog2(block_size);
    localparam logic [3:0]  STRADDLE_OFF = 4'(block_size / 8 - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [LINE_W-1:0]      set_addr_q, set_addr_d;
    logic [block_size-1:0]  set_block_q, set_block_d;
    logic                   set_we_q, set_we_d;
    logic                   l2_req_q, l2_req_d;
    logic [LINE_W-1:0]      l2_addr_q, l2_addr_d;

    logic [3:0]             off;
    logic                   straddle;
    logic [LINE_W-1:0]      cur_line;
    logic [LINE_W-1:0]      nxt_line;
    logic                   hit_cur;
    logic                   hit_nxt;
    logic [SEL_W-1:0]       bit_sel;

    // Address decode and tag compare for the current and following line
    always_comb begin
        off      = addr_q[3:0] & 4'hE;
        straddle = (off == STRADDLE_OFF);
        cur_line = addr_q[ADDR_W-1:4];
        nxt_line = cur_line + LINE_W'(1);
        hit_cur  = set_valid_i && (set_tag_i == addr_q[ADDR_W-1 -: tag_size]);
        hit_nxt  = set_valid_next_i && (set_tag_next_i == nxt_line[LINE_W-1 -: tag_size]);
        bit_sel  = SEL_W'({off, 3'b000});
    end

    // Set address, write strobe and refill request are registered: the set sees
    // the address chosen here one cycle later, so after WRITE the re-lookup in
    // LOOKUP already reads the fetch line (with the new data written).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        set_addr_d  = set_addr_q;
        set_block_d = set_block_q;
        set_we_d    = 1'b0;
        l2_req_d    = l2_req_q;
        l2_addr_d   = l2_addr_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req_i) begin
                    addr_d     = fetch_addr_i;
                    set_addr_d = fetch_addr_i[ADDR_W-1:4];
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_cur && (!straddle || hit_nxt)) begin
                    state_d = RESP;
                end else begin
                    // current line always refilled first, next line on a later pass
                    l2_req_d  = 1'b1;
                    l2_addr_d = hit_cur ? nxt_line : cur_line;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (l2_ack_i) begin
                    l2_req_d    = 1'b0;
                    set_we_d    = 1'b1;
                    set_addr_d  = l2_addr_q;
                    set_block_d = l2_block_i;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                set_addr_d = cur_line;
                state_d    = LOOKUP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered set/L2 outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            set_addr_q  <= '0;
            set_block_q <= '0;
            set_we_q    <= 1'b0;
            l2_req_q    <= 1'b0;
            l2_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            set_addr_q  <= set_addr_d;
            set_block_q <= set_block_d;
            set_we_q    <= set_we_d;
            l2_req_q    <= l2_req_d;
            l2_addr_q   <= l2_addr_d;
        end
    end

    // Instruction extraction during RESP, including the two-line straddle
    always_comb begin
        instr_o = '0;
        if (state_q == RESP) begin
            if (straddle) begin
                instr_o = {set_block_next_i, set_block_i[block_size-1 -: 16]};
            end else begin
                instr_o = set_block_i[bit_sel +: 32];
            end
        end
    end

    assign fetch_ready_o     = (state_q == IDLE);
    assign instr_valid_o     = (state_q == RESP);
    assign set_tag_and_idx_o = set_addr_q;
    assign set_block_o       = set_block_q;
    assign set_we_o          = set_we_q;
    assign set_we_next_o     = 1'b0;
    assign l2_req_o          = l2_req_q;
    assign l2_addr_o         = l2_addr_q;

`ifdef L1I_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counts of LOOKUP outcomes
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP && state_d == RESP && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (state_q == LOOKUP && state_d == REFILL && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_instr_fetch_ctrl.sv
// Self-checking bench for l1_instr_fetch_ctrl: behavioural cache set and L2,
// directed scenarios followed by randomized fetches checked against a
// line-level reference model.
module tb_l1_instr_fetch_ctrl;

    logic         clk;
    logic         rst_ni;
    logic         fetch_req_i;
    logic [18:0]  fetch_addr_i;
    logic         fetch_ready_o;
    logic         instr_valid_o;
    logic [31:0]  instr_o;
    logic [14:0]  set_tag_and_idx_o;
    logic [127:0] set_block_o;
    logic         set_we_o;
    logic         set_we_next_o;
    logic [127:0] set_block_i;
    logic         set_valid_i;
    logic [8:0]   set_tag_i;
    logic [15:0]  set_block_next_i;
    logic         set_valid_next_i;
    logic [8:0]   set_tag_next_i;
    logic         l2_req_o;
    logic [14:0]  l2_addr_o;
    logic         l2_ack_i;
    logic [127:0] l2_block_i;
`ifdef L1I_PERF_CNT_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    l1_instr_fetch_ctrl #(
        .block_size(128),
        .tag_size  (9),
        .idx_size  (6)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .fetch_req_i      (fetch_req_i),
        .fetch_addr_i     (fetch_addr_i),
        .fetch_ready_o    (fetch_ready_o),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .set_tag_and_idx_o(set_tag_and_idx_o),
        .set_block_o      (set_block_o),
        .set_we_o         (set_we_o),
        .set_we_next_o    (set_we_next_o),
        .set_block_i      (set_block_i),
        .set_valid_i      (set_valid_i),
        .set_tag_i        (set_tag_i),
        .set_block_next_i (set_block_next_i),
        .set_valid_next_i (set_valid_next_i),
        .set_tag_next_i   (set_tag_next_i),
        .l2_req_o         (l2_req_o),
        .l2_addr_o        (l2_addr_o),
        .l2_ack_i         (l2_ack_i),
`ifdef L1I_PERF_CNT_EN
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o),
`endif
        .l2_block_i       (l2_block_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural cache set ----------------
    logic         sv_valid [64];
    logic [8:0]   sv_tag   [64];
    logic [127:0] sv_blk   [64];
    logic         inv_req;
    logic [5:0]   rd_idx;
    logic [5:0]   rd_nidx;

    assign rd_idx           = set_tag_and_idx_o[5:0];
    assign rd_nidx          = rd_idx + 6'd1;
    assign set_block_i      = sv_blk[rd_idx];
    assign set_valid_i      = sv_valid[rd_idx];
    assign set_tag_i        = sv_tag[rd_idx];
    assign set_block_next_i = sv_blk[rd_nidx][15:0];
    assign set_valid_next_i = sv_valid[rd_nidx];
    assign set_tag_next_i   = sv_tag[rd_nidx];

    always @(posedge clk) begin
        if (inv_req) begin
            for (int i = 0; i < 64; i++) sv_valid[i] <= 1'b0;
        end else if (set_we_o) begin
            sv_valid[set_tag_and_idx_o[5:0]] <= 1'b1;
            sv_tag[set_tag_and_idx_o[5:0]]   <= set_tag_and_idx_o[14:6];
            sv_blk[set_tag_and_idx_o[5:0]]   <= set_block_o;
        end
    end

    // ---------------- reference model ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          m_valid [64];
    logic [8:0]  m_tag   [64];
    int unsigned exp_hit  = 0;
    int unsigned exp_miss = 0;
    logic [14:0] obs_lines[$];

    // L2 contents: byte at any 19-bit address is a fixed function of it
    function automatic logic [7:0] l2_byte(input logic [18:0] x);
        logic [18:0] d;
        d = x - 19'd16;
        return d[7:0] ^ x[15:8] ^ {5'd0, x[18:16]};
    endfunction

    function automatic logic [127:0] l2_line(input logic [14:0] line);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[k*8 +: 8] = l2_byte({line, 4'(k)});
        return b;
    endfunction

    function automatic bit m_hit(input logic [14:0] line);
        return m_valid[line[5:0]] && (m_tag[line[5:0]] == line[14:6]);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic invalidate_all();
        @(negedge clk);
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // One complete fetch with L2 wait states up to max_w; returns observed instruction
    task automatic run_fetch(input logic [18:0] a_in, input int unsigned max_w,
                             output logic [31:0] got);
        logic [18:0]  a;
        logic [14:0]  cur;
        logic [14:0]  nxt;
        logic [14:0]  exp_q[$];
        logic [14:0]  line;
        logic [127:0] blk;
        logic [31:0]  exp_instr;
        int unsigned  exp_lat;
        int unsigned  cyc;
        int unsigned  w;
        int unsigned  wc;
        int unsigned  n_ref;
        int unsigned  n_wr;
        bit           in_req;
        bit           done;

        a   = {a_in[18:1], 1'b0};
        cur = a[18:4];
        nxt = cur + 15'd1;
        if (!m_hit(cur)) begin
            exp_q.push_back(cur);
            m_valid[cur[5:0]] = 1'b1;
            m_tag[cur[5:0]]   = cur[14:6];
        end
        if (a[3:0] == 4'd14 && !m_hit(nxt)) begin
            exp_q.push_back(nxt);
            m_valid[nxt[5:0]] = 1'b1;
            m_tag[nxt[5:0]]   = nxt[14:6];
        end
        n_ref     = exp_q.size();
        exp_instr = {l2_byte(a + 19'd3), l2_byte(a + 19'd2), l2_byte(a + 19'd1), l2_byte(a)};
        exp_miss += n_ref;
        exp_hit++;
        obs_lines.delete();
        got = '0;

        cyc = 0;
        while (!fetch_ready_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("fetch_ready", fetch_ready_o, 1'b1);
        fetch_req_i  = 1'b1;
        fetch_addr_i = a_in;
        @(posedge clk);
        #1;
        fetch_req_i  = 1'b0;
        fetch_addr_i = 19'($urandom);

        exp_lat = 2;
        cyc     = 0;
        done    = 1'b0;
        in_req  = 1'b0;
        n_wr    = 0;
        w       = 0;
        wc      = 0;
        line    = '0;
        blk     = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            l2_ack_i = 1'b0;
            if (set_we_o) begin
                n_wr++;
                check("set_we_addr", set_tag_and_idx_o, line);
                check("set_we_block", set_block_o, blk);
            end
            if (l2_req_o) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    check("refill_expected", exp_q.size() > 0, 1'b1);
                    line = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0;
                    obs_lines.push_back(l2_addr_o);
                    check("l2_addr", l2_addr_o, line);
                    w  = $urandom_range(max_w);
                    wc = 0;
                    exp_lat += w + 3;
                end else begin
                    check("l2_addr_stable", l2_addr_o, line);
                end
                if (wc == w) begin
                    blk        = l2_line(line);
                    l2_ack_i   = 1'b1;
                    l2_block_i = blk;
                    in_req     = 1'b0;
                end else begin
                    wc++;
                end
            end
            if (instr_valid_o) begin
                done = 1'b1;
                got  = instr_o;
                check("instr", instr_o, exp_instr);
                check("latency", cyc, exp_lat);
                if (a[3:0] == 4'd14) check("tag_next", set_tag_next_i, nxt[14:6]);
            end
        end
        l2_ack_i = 1'b0;
        check("completed", done, 1'b1);
        check("refills_left", exp_q.size(), 0);
        check("write_count", n_wr, n_ref);
        check("we_next", set_we_next_o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [18:0] ra;
        int unsigned cyc;

        rst_ni       = 1'b0;
        fetch_req_i  = 1'b0;
        fetch_addr_i = '0;
        l2_ack_i     = 1'b0;
        l2_block_i   = '0;
        inv_req      = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        repeat (3) @(negedge clk);
        inv_req = 1'b0;

        // reset values
        check("rst_ready", fetch_ready_o, 1'b1);
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_set_addr", set_tag_and_idx_o, 15'h0);
        check("rst_set_block", set_block_o, 128'h0);
        check("rst_we", set_we_o, 1'b0);
        check("rst_l2_req", l2_req_o, 1'b0);
        check("rst_l2_addr", l2_addr_o, 15'h0);
`ifdef L1I_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt_o, 32'h0);
        check("rst_miss_cnt", miss_cnt_o, 32'h0);
`endif
        rst_ni = 1'b1;

        // cold miss then repeat hit on the same line
        run_fetch(19'h00010, 2, got);
        check("cold_instr", got, 32'h03020100);
        check("cold_refill_n", obs_lines.size(), 1);
        check("cold_refill_addr", obs_lines[0], 15'h0001);
        run_fetch(19'h00014, 2, got);
        check("repeat_instr", got, 32'h07060504);
        check("repeat_refill_n", obs_lines.size(), 0);
`ifdef L1I_PERF_CNT_EN
        check("perf_miss_after_two", miss_cnt_o, 32'd1);
        check("perf_hit_after_two", hit_cnt_o, 32'd2);
`endif

        // straddle with both lines invalid
        invalidate_all();
        run_fetch(19'h0001E, 1, got);
        check("straddle_instr", got, 32'h11100F0E);
        check("straddle_refill_n", obs_lines.size(), 2);
        check("straddle_first", obs_lines[0], 15'h0001);
        check("straddle_second", obs_lines[1], 15'h0002);

        // index wrap: idx 63 straddles into tag+1, idx 0
        run_fetch(19'h003FE, 0, got);
        check("wrap_refill_n", obs_lines.size(), 2);
        check("wrap_next_line", obs_lines[1], 15'h0040);

        // reset while a refill is outstanding
        invalidate_all();
        @(negedge clk);
        fetch_req_i  = 1'b1;
        fetch_addr_i = 19'h12340;
        @(posedge clk);
        #1;
        fetch_req_i = 1'b0;
        cyc = 0;
        while (!l2_req_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_req_seen", l2_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("midrst_req_drop", l2_req_o, 1'b0);
        check("midrst_we", set_we_o, 1'b0);
        check("midrst_ready", fetch_ready_o, 1'b1);
        check("midrst_l2_addr", l2_addr_o, 15'h0);
        exp_hit  = 0;
        exp_miss = 0;
        @(negedge clk);
        l2_ack_i   = 1'b1;
        l2_block_i = {4{$urandom}};
        @(negedge clk);
        l2_ack_i = 1'b0;
        rst_ni   = 1'b1;
        @(negedge clk);
        l2_ack_i = 1'b1;
        @(negedge clk);
        l2_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("postrst_we", set_we_o, 1'b0);
            check("postrst_req", l2_req_o, 1'b0);
            check("postrst_ready", fetch_ready_o, 1'b1);
            @(negedge clk);
        end

        // randomized fetches over a small address window to mix hits and misses
        for (int i = 0; i < 40; i++) begin
            ra[18:10] = 9'($urandom_range(0, 1));
            ra[9:4]   = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 5));
            ra[3:0]   = 4'($urandom_range(0, 15));
            run_fetch(ra, 3, got);
        end

`ifdef L1I_PERF_CNT_EN
        check("perf_hit_final", hit_cnt_o, exp_hit);
        check("perf_miss_final", miss_cnt_o, exp_miss);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
